// File: rtl/scalar_mult_ctrl.sv
// Ed25519 scalar multiplication sequencer (left-to-right double-and-add).
// Drives the point adder request port and holds P and Q in extended coords.
module scalar_mult_ctrl #(
  parameter int W = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_scalar,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_zero,
  output logic [W-1:0] o_x,
  output logic [W-1:0] o_y,
  output logic [W-1:0] o_z,
  output logic [W-1:0] o_t,
  output logic         o_pa_start,
  output logic         o_pa_doubling,
  output logic         o_pa_initial,
  output logic [W-1:0] o_pa_x1,
  output logic [W-1:0] o_pa_y1,
  output logic [W-1:0] o_pa_z1,
  output logic [W-1:0] o_pa_t1,
  output logic [W-1:0] o_pa_x2,
  output logic [W-1:0] o_pa_y2,
  output logic [W-1:0] o_pa_z2,
  output logic [W-1:0] o_pa_t2,
  input  logic [W-1:0] i_pa_x3,
  input  logic [W-1:0] i_pa_y3,
  input  logic [W-1:0] i_pa_z3,
  input  logic [W-1:0] i_pa_t3,
  input  logic         i_pa_finished
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_INIT_W,
    S_DBL,
    S_DBL_W,
    S_ADD,
    S_ADD_W,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0] k_r, x_r, y_r;
  logic [W-1:0] px, py, pz, pt;
  logic [W-1:0] qx, qy, qz, qt;
  logic [7:0]   idx_r, msb;
  logic         zero_r;

  // Index of the most-significant set bit of the incoming scalar.
  always_comb begin
    msb = '0;
    for (int i = 0; i < W; i++)
      if (i_scalar[i]) msb = 8'(i);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; idx_r already points at the bit being processed.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (i_start)
          state_nxt = (i_scalar == '0) ? S_DONE : S_INIT;
      S_INIT:
        state_nxt = S_INIT_W;
      S_INIT_W, S_ADD_W:
        if (i_pa_finished)
          state_nxt = (idx_r == '0) ? S_DONE : S_DBL;
      S_DBL:
        state_nxt = S_DBL_W;
      S_DBL_W:
        if (i_pa_finished) begin
          if (k_r[idx_r])         state_nxt = S_ADD;
          else if (idx_r == '0)   state_nxt = S_DONE;
          else                    state_nxt = S_DBL;
        end
      S_ADD:
        state_nxt = S_ADD_W;
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // Operand latching, request issue and result capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_r           <= '0;
      x_r           <= '0;
      y_r           <= '0;
      px            <= '0;
      py            <= '0;
      pz            <= '0;
      pt            <= '0;
      qx            <= '0;
      qy            <= '0;
      qz            <= '0;
      qt            <= '0;
      idx_r         <= '0;
      zero_r        <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_zero        <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_z           <= '0;
      o_t           <= '0;
      o_pa_start    <= 1'b0;
      o_pa_doubling <= 1'b0;
      o_pa_initial  <= 1'b0;
      o_pa_x1       <= '0;
      o_pa_y1       <= '0;
      o_pa_z1       <= '0;
      o_pa_t1       <= '0;
      o_pa_x2       <= '0;
      o_pa_y2       <= '0;
      o_pa_z2       <= '0;
      o_pa_t2       <= '0;
    end else begin
      o_pa_start <= 1'b0;
      o_done     <= 1'b0;
      o_zero     <= 1'b0;
      unique case (state)
        S_IDLE:
          if (i_start) begin
            k_r    <= i_scalar;
            x_r    <= i_x;
            y_r    <= i_y;
            idx_r  <= msb;
            zero_r <= (i_scalar == '0);
            o_busy <= 1'b1;
            qx     <= '0;
            qy     <= '0;
            qz     <= '0;
            qt     <= '0;
          end
        S_INIT: begin
          o_pa_start    <= 1'b1;
          o_pa_initial  <= 1'b1;
          o_pa_doubling <= 1'b0;
          o_pa_x1       <= x_r;
          o_pa_y1       <= y_r;
          o_pa_z1       <= '0;
          o_pa_t1       <= '0;
          o_pa_x2       <= '0;
          o_pa_y2       <= '0;
          o_pa_z2       <= '0;
          o_pa_t2       <= '0;
        end
        S_INIT_W:
          if (i_pa_finished) begin
            px <= i_pa_x3;
            py <= i_pa_y3;
            pz <= i_pa_z3;
            pt <= i_pa_t3;
            qx <= i_pa_x3;
            qy <= i_pa_y3;
            qz <= i_pa_z3;
            qt <= i_pa_t3;
          end
        S_DBL: begin
          idx_r         <= idx_r - 8'd1;
          o_pa_start    <= 1'b1;
          o_pa_initial  <= 1'b0;
          o_pa_doubling <= 1'b1;
          o_pa_x1       <= qx;
          o_pa_y1       <= qy;
          o_pa_z1       <= qz;
          o_pa_t1       <= qt;
          o_pa_x2       <= qx;
          o_pa_y2       <= qy;
          o_pa_z2       <= qz;
          o_pa_t2       <= qt;
        end
        S_DBL_W, S_ADD_W:
          if (i_pa_finished) begin
            qx <= i_pa_x3;
            qy <= i_pa_y3;
            qz <= i_pa_z3;
            qt <= i_pa_t3;
          end
        S_ADD: begin
          o_pa_start    <= 1'b1;
          o_pa_initial  <= 1'b0;
          o_pa_doubling <= 1'b0;
          o_pa_x1       <= qx;
          o_pa_y1       <= qy;
          o_pa_z1       <= qz;
          o_pa_t1       <= qt;
          o_pa_x2       <= px;
          o_pa_y2       <= py;
          o_pa_z2       <= pz;
          o_pa_t2       <= pt;
        end
        S_DONE: begin
          o_done <= 1'b1;
          o_zero <= zero_r;
          o_busy <= 1'b0;
          o_x    <= qx;
          o_y    <= qy;
          o_z    <= qz;
          o_t    <= qt;
        end
        default: ;
      endcase
    end
  end

endmodule
